// File: rtl/str_rr_arb_pkg.sv
// Shared types and helpers for the round-robin byte arbiter.
// Optional statistics are enabled with the STR_RR_ARB_STATS_EN macro.
package str_rr_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int STATS_W = 16;

    // Successor of idx in a ring of n entries.
    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/str_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module str_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (SRC_W + 1)'(off);
            if (sum >= (SRC_W + 1)'(NUM_REQ)) begin
                sum = sum - (SRC_W + 1)'(NUM_REQ);
            end
            idx = sum[SRC_W-1:0];
            if (!any_grant && elig[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/str_rr_byte_arbiter.sv
// Round-robin arbiter owning a shared byte register; tags each word with its source.
// Define STR_RR_ARB_STATS_EN to add per-requester grant counters (grant_cnt, stats_clr).
import str_rr_arb_pkg::*;

module str_rr_byte_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_en_mask,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    output logic                        busy,
    output state_e                      dbg_state,
    output logic [$clog2(NUM_REQ)-1:0]  dbg_rr_ptr
`ifdef STR_RR_ARB_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [NUM_REQ*STATS_W-1:0]  grant_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // Handshake: an input word moves when req_valid[i] & req_ready[i]; the held word
    // leaves when out_valid & out_ready. req_ready is a one-hot grant, never data-dependent.
    state_e             state, state_nxt;
    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               any_grant;
    logic               can_load;
    logic               load;

    assign elig = req_valid & req_en_mask;

    str_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (!load && out_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        can_load  = (state == EMPTY) || out_ready;
        load      = can_load && any_grant && !rst;
        req_ready = load ? grant : '0;
        out_valid = (state == FULL);
        busy      = (state == FULL) || (|elig);
    end

    // A load overwrites the held word in the same cycle it drains, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            data_out <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            out_src  <= grant_idx;
            rr_ptr   <= SRC_W'(next_ptr(int'(grant_idx), NUM_REQ));
        end
    end

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

`ifdef STR_RR_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [STATS_W-1:0] cnt_q;

        // Clear wins over a same-cycle grant; counting stops at all-ones.
        always_ff @(posedge clk) begin
            if (rst || stats_clr) begin
                cnt_q <= '0;
            end else if (req_ready[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign grant_cnt[i*STATS_W +: STATS_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_str_rr_byte_arbiter.sv
// Directed self-checking bench for str_rr_byte_arbiter (NUM_REQ=4, DATA_W=8).
// Statistics scenarios compile in when STR_RR_ARB_STATS_EN is defined.
module tb_str_rr_byte_arbiter;
    import str_rr_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_en_mask;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic        busy;
    state_e      dbg_state;
    logic [1:0]  dbg_rr_ptr;
`ifdef STR_RR_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    str_rr_byte_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_en_mask (req_en_mask),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src),
        .busy        (busy),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
`ifdef STR_RR_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_en_mask = 4'b1111; req_valid = 4'b1111;
        req_data = {8'h40, 8'h30, 8'h20, 8'h10}; out_ready = 1'b1;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if (out_src !== 2'd0) begin bad++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
        rst = 1'b0; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", req_ready); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_d = 8'((k % 4 + 1) * 16);
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rot_ready[%0d] got=%b exp=%b", k, req_ready, exp_g); end
            step();
            total++; if (out_src !== 2'(k % 4) || data_out !== exp_d || out_valid !== 1'b1) begin
                bad++; $display("FAIL rot_out[%0d] got src=%0d data=%h v=%b exp src=%0d data=%h v=1", k, out_src, data_out, out_valid, k % 4, exp_d);
            end
        end
        req_valid = 4'b0000; step();
        total++; if (out_valid !== 1'b0 || dbg_state !== EMPTY) begin bad++; $display("FAIL rot_drain got v=%b st=%0d exp v=0 st=0", out_valid, dbg_state); end
        total++; if (dbg_rr_ptr !== 2'd1) begin bad++; $display("FAIL rot_ptr got=%0d exp=1", dbg_rr_ptr); end
    endtask

    task automatic test_back_pressure();
        req_valid = 4'b0100; req_data = {8'h55, 8'hAA, 8'h00, 8'h00}; out_ready = 1'b0; #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_load_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (data_out !== 8'hAA || out_src !== 2'd2 || out_valid !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold[%0d] got data=%h src=%0d v=%b rdy=%b exp data=aa src=2 v=1 rdy=0000", k, data_out, out_src, out_valid, req_ready);
            end
            step();
        end
        out_ready = 1'b1; #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b exp=1000", req_ready); end
        step();
        total++; if (data_out !== 8'h55 || out_src !== 2'd3 || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_no_bubble got data=%h src=%0d v=%b exp data=55 src=3 v=1", data_out, out_src, out_valid);
        end
        req_valid = 4'b0000; step();
        total++; if (out_valid !== 1'b0 || dbg_rr_ptr !== 2'd0) begin bad++; $display("FAIL bp_wrap got v=%b ptr=%0d exp v=0 ptr=0", out_valid, dbg_rr_ptr); end
    endtask

    task automatic test_masking();
        logic [3:0] exp_g;
        req_en_mask = 4'b1010; req_valid = 4'b1111;
        req_data = {8'h40, 8'h30, 8'h20, 8'h10}; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            #1;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL mask_ready[%0d] got=%b exp=%b", k, req_ready, exp_g); end
            step();
            total++; if (out_src !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin bad++; $display("FAIL mask_src[%0d] got=%0d", k, out_src); end
        end
        req_en_mask = 4'b0000; #1;
        total++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL allmask_ready got rdy=%b busy=%b exp rdy=0000 busy=1", req_ready, busy); end
        step();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL allmask_drain got v=%b busy=%b exp v=0 busy=0", out_valid, busy); end
        req_en_mask = 4'b1111; req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_stall();
        req_valid = 4'b0010; req_data = {8'h00, 8'h00, 8'h5A, 8'h00}; out_ready = 1'b0;
        step();
        req_valid = 4'b0000; step();
        total++; if (data_out !== 8'h5A || out_valid !== 1'b1 || dbg_rr_ptr !== 2'd2) begin
            bad++; $display("FAIL stall_hold got data=%h v=%b ptr=%0d exp data=5a v=1 ptr=2", data_out, out_valid, dbg_rr_ptr);
        end
        rst = 1'b1; step(); rst = 1'b0; #1;
        total++; if (out_valid !== 1'b0 || data_out !== 8'h00 || dbg_rr_ptr !== 2'd0 || dbg_state !== EMPTY) begin
            bad++; $display("FAIL mid_reset got v=%b data=%h ptr=%0d st=%0d exp v=0 data=00 ptr=0 st=0", out_valid, data_out, dbg_rr_ptr, dbg_state);
        end
        out_ready = 1'b1;
    endtask

`ifdef STR_RR_ARB_STATS_EN
    task automatic test_stats();
        total++; if (grant_cnt !== 64'd0) begin bad++; $display("FAIL stats_reset got=%h exp=0", grant_cnt); end
        req_valid = 4'b0010; out_ready = 1'b1;
        step(); step(); step();
        req_valid = 4'b0000;
        total++; if (grant_cnt[16 +: 16] !== 16'd3 || grant_cnt[0 +: 16] !== 16'd0) begin
            bad++; $display("FAIL stats_three got c1=%0d c0=%0d exp c1=3 c0=0", grant_cnt[16 +: 16], grant_cnt[0 +: 16]);
        end
        req_valid = 4'b0010; stats_clr = 1'b1; step(); stats_clr = 1'b0;
        total++; if (grant_cnt !== 64'd0) begin bad++; $display("FAIL stats_clr got=%h exp=0", grant_cnt); end
        for (int k = 0; k < 70000; k++) step();
        req_valid = 4'b0000;
        total++; if (grant_cnt[16 +: 16] !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", grant_cnt[16 +: 16]); end
    endtask
`endif

    initial begin
`ifdef STR_RR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_back_pressure();
        test_masking();
        test_reset_mid_stall();
`ifdef STR_RR_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/str_rr_byte_arbiter.md
Name: str_rr_byte_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared byte-wide pipeline register (data_out <= data_in).
- Multiple requesters compete to load the register over a valid/ready handshake.
- The block owns the register, tags each word with its source index, and holds it until the downstream consumer accepts it.
- Sits between testbench/stimulus agents or multiple producer blocks and a single byte-wide sink.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, payload width in bits.
- SRC_W, $clog2(NUM_REQ), derived (localparam); width of the source tag.

Ports:
- clk  input  1  single clock; all logic on posedge clk.
- rst  input  1  reset; synchronous and active-high.
- req_en_mask  input  NUM_REQ  per-requester enable; masked requesters are never granted.
- req_valid  input  NUM_REQ  requester i has a word.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant/accept; word i is transferred when req_valid[i] & req_ready[i].
- data_out  output  DATA_W  registered payload.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  sink accepts; transfer occurs when out_valid & out_ready.
- out_src  output  SRC_W  index of the requester that supplied data_out.
- busy  output  1  out_valid, or any eligible request pending.

Behaviour:
- Reset (rst=1 at posedge): data_out=0, out_valid=0, out_src=0, rr_ptr=0, state=EMPTY. req_ready is 0 during reset.
- Reset mid-operation discards the held word without a handshake.
- Eligible set: elig = req_valid & req_en_mask.
- Grant selection (combinational): the first set bit of elig, searching from rr_ptr upward with wrap modulo NUM_REQ.
- can_load = (state==EMPTY) | out_ready.
- req_ready = onehot(grant) when can_load and elig != 0; otherwise 0. At most one bit is set. req_ready never depends on req_data.
- On load: data_out <= selected word; out_src <= grant index; out_valid <= 1; rr_ptr <= (grant+1) mod NUM_REQ.
- rr_ptr changes only on a load.
- State FULL, out_ready=1, no eligible request: out_valid <= 0 and state goes to EMPTY.
- State FULL, out_ready=0: data_out, out_src and out_valid hold stable and no request is granted.
- Throughput is one word per cycle when the sink is always ready. Latency from request accept to out_valid is 1 cycle.
- FSM:
  - EMPTY: to FULL on load.
  - FULL: stays FULL on load or stall; to EMPTY on drain with no load.
- Simultaneous drain and load in the same cycle: the new word replaces the old with no bubble.
- Mask change: takes effect the same cycle (combinational). A masked requester keeping valid high never sees ready.
- All requesters masked: no loads occur; any held word still drains.
- Wrap: rr_ptr goes from NUM_REQ-1 to 0.

Optional Feature:
- Macro: STR_RR_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16 bits): per-requester saturating 16-bit counts of accepted loads.
  - Adds input stats_clr (1 bit): synchronous zero of all counters. If stats_clr and a grant occur in the same cycle, the counter reads 0.
  - Counters reset to 0 on rst.
- Undefined: neither port exists, no counter logic is generated, and arbitration behaviour is identical.

Decomposition:
- Package str_rr_arb_pkg:
  - state_e enum {EMPTY, FULL}.
  - STATS_W=16 constant.
  - Function next_ptr(idx, n).
- Sub-module str_rr_pick: purely combinational. Inputs elig and rr_ptr; outputs a one-hot grant and a grant index plus any_grant. Instantiated once.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all req_valid=1 -> out_valid=0, data_out=8'h00, req_ready=0. First grant after reset goes to requester 0.
- Fair rotation: all 4 valid with data 8'h10/8'h20/8'h30/8'h40, out_ready=1 -> out_src sequence 0,1,2,3,0. data_out shows 8'h10, 8'h20, 8'h30, 8'h40 on consecutive cycles.
- Back-pressure: load 8'hAA from requester 2, hold out_ready=0 for 5 cycles -> data_out=8'hAA, out_src=2 stable, req_ready=0 throughout. Raise out_ready and requester 3 (8'h55) loads in the same cycle with no bubble.
- Masking: req_en_mask=4'b1010, all valid -> grants alternate between 1 and 3 only. Requesters 0 and 2 never see ready.
- Reset mid-stall: word 8'h5A held with out_ready=0, assert rst for 1 cycle -> out_valid=0, data_out=8'h00 next cycle, rr_ptr=0.
- Stats (STR_RR_ARB_STATS_EN defined): 3 loads from requester 1 -> grant_cnt[1]=3. Pulse stats_clr -> all counters 0. 70000 loads -> counter saturates at 16'hFFFF.
